frame_block_reader: RTL and testbench

FRAME_BLOCK_READER -- requirements
Module: frame_block_reader

---
 rtl/frame_pkg.sv | 36 +++
 rtl/fb_row_fifo.sv | 61 ++++++
 rtl/frame_block_reader.sv | 167 ++++++++++++++++
 tb/tb_frame_block_reader.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/frame_pkg.sv
// Shared definitions for the frame block reader: geometry/coordinate widths,
// block shape, FSM state type and the row word-address helper.
package frame_pkg;

  localparam int unsigned GeomW      = 12;  // stride/width/height
  localparam int unsigned CoordW     = 11;  // block pixel coordinates
  localparam int unsigned PixPerWord = 8;   // luma pixels per memory word
  localparam int unsigned BlkSize    = 8;   // block is BlkSize x BlkSize pixels
  localparam int unsigned RowW       = $clog2(BlkSize);
  // y*stride needs 2*GeomW bits; one extra bit absorbs the +x carry.
  localparam int unsigned AddrCalcW  = 2 * GeomW + 1;

  typedef enum logic [1:0] {
    StIdle,
    StFetch,
    StDrain
  } state_e;

  // Word address of block row r. Rows below the frame replicate the last row.
  function automatic logic [AddrCalcW-1:0] row_word_addr(
    input logic [GeomW-1:0]  stride,
    input logic [GeomW-1:0]  height,
    input logic [CoordW-1:0] x,
    input logic [CoordW-1:0] y,
    input logic [RowW-1:0]   r
  );
    logic [GeomW-1:0]     row_y;
    logic [GeomW-1:0]     clamp_y;
    logic [AddrCalcW-1:0] pix;
    row_y   = GeomW'(y) + GeomW'(r);
    clamp_y = (row_y >= height) ? (height - GeomW'(1)) : row_y;
    pix     = AddrCalcW'(clamp_y) * AddrCalcW'(stride) + AddrCalcW'(x);
    return pix >> $clog2(PixPerWord);
  endfunction

endpackage

// File: rtl/fb_row_fifo.sv
// Show-ahead row FIFO: head_data always presents the oldest entry while
// not_empty is high. Occupancy is a register, not derived from pointers.
//   clk, reset     clock, synchronous active-high reset
//   push/push_data write one entry (dropped only if full and not popping)
//   pop            remove the head entry (ignored when empty)
//   head_data      oldest entry
//   not_empty      at least one entry stored
//   count          current occupancy
module fb_row_fifo #(
  parameter int unsigned Width = 64,
  parameter int unsigned Depth = 4,
  localparam int unsigned PtrW = $clog2(Depth),
  localparam int unsigned CntW = $clog2(Depth + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [Width-1:0] push_data,
  input  logic             pop,
  output logic [Width-1:0] head_data,
  output logic             not_empty,
  output logic [CntW-1:0]  count
);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]  cnt_q;
  logic             full, do_push, do_pop;

  // Depth need not be a power of two, so wrap explicitly.
  function automatic logic [PtrW-1:0] inc_ptr(input logic [PtrW-1:0] p);
    return (p == PtrW'(Depth - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    full    = (cnt_q == CntW'(Depth));
    do_pop  = pop && (cnt_q != '0);
    do_push = push && (!full || do_pop);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (do_push) wr_ptr_q <= inc_ptr(wr_ptr_q);
      if (do_pop)  rd_ptr_q <= inc_ptr(rd_ptr_q);
      cnt_q <= cnt_q + CntW'(do_push) - CntW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

  assign head_data = mem_q[rd_ptr_q];
  assign not_empty = (cnt_q != '0);
  assign count     = cnt_q;

endmodule

// File: rtl/frame_block_reader.sv
// Fetches one 8x8 luma block from word-addressed frame memory, one 8-pixel
// word per block row, and streams the rows out through a valid/ready port.
//   clk, reset                   clock, synchronous active-high reset
//   setup_frame, stride_in,
//   width_in, height_in          frame geometry, latched while idle
//   blk_req, blk_x, blk_y        block fetch request (8-aligned top-left pixel)
//   blk_busy, blk_err            fetch in progress / one-cycle reject pulse
//   mem_rd_en, mem_addr,
//   mem_rd_data                  memory read port, data one cycle after strobe
//   out_valid, out_ready,
//   out_data, out_row, out_last  block row stream, row 7 flagged last
module frame_block_reader
  import frame_pkg::*;
#(
  parameter int unsigned MEM_WIDTH  = 64,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  setup_frame,
  input  logic [GeomW-1:0]      stride_in,
  input  logic [GeomW-1:0]      width_in,
  input  logic [GeomW-1:0]      height_in,
  input  logic                  blk_req,
  input  logic [CoordW-1:0]     blk_x,
  input  logic [CoordW-1:0]     blk_y,
  output logic                  blk_busy,
  output logic                  blk_err,
  output logic                  mem_rd_en,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [MEM_WIDTH-1:0]  mem_rd_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [MEM_WIDTH-1:0]  out_data,
  output logic [RowW-1:0]       out_row,
  output logic                  out_last
);

  localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned OccW = CntW + 1;

  state_e                state_q;
  logic                  geom_valid_q;
  logic [GeomW-1:0]      stride_q, width_q, height_q;
  logic [CoordW-1:0]     bx_q, by_q;
  logic [RowW:0]         rd_cnt_q;   // reads issued for the current block, 0..8
  logic [RowW-1:0]       out_cnt_q;  // rows handed to the consumer
  logic                  rd_en_q;
  logic                  rd_vld_q;   // read data is on mem_rd_data this cycle
  logic                  err_q;
  logic [ADDR_WIDTH-1:0] addr_q;

  logic [MEM_WIDTH-1:0]  fifo_head;
  logic                  fifo_nempty;
  logic [CntW-1:0]       fifo_cnt;
  logic                  pop;
  logic                  req_ok;
  logic [AddrCalcW-1:0]  next_addr;
  logic [OccW-1:0]       occ_nxt;
  logic                  can_issue;

  always_comb begin
    pop    = fifo_nempty && out_ready;
    req_ok = geom_valid_q
          && (GeomW'(blk_x) < width_q) && (GeomW'(blk_y) < height_q)
          && (blk_x[2:0] == 3'd0) && (blk_y[2:0] == 3'd0);

    // Idle computes row 0 straight from the request; fetch uses latched coords.
    if (state_q == StIdle) begin
      next_addr = row_word_addr(stride_q, height_q, blk_x, blk_y, '0);
    end else begin
      next_addr = row_word_addr(stride_q, height_q, bx_q, by_q, rd_cnt_q[RowW-1:0]);
    end

    // The strobe is registered, so decide on next-cycle occupancy; the read
    // issued this cycle becomes the one in flight next cycle.
    occ_nxt   = OccW'(fifo_cnt) + OccW'(rd_vld_q) - OccW'(pop);
    can_issue = (occ_nxt + OccW'(rd_en_q)) < OccW'(FIFO_DEPTH);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      geom_valid_q <= 1'b0;
      stride_q     <= '0;
      width_q      <= '0;
      height_q     <= '0;
      bx_q         <= '0;
      by_q         <= '0;
      rd_cnt_q     <= '0;
      out_cnt_q    <= '0;
      rd_en_q      <= 1'b0;
      rd_vld_q     <= 1'b0;
      err_q        <= 1'b0;
      addr_q       <= '0;
    end else begin
      err_q    <= 1'b0;
      rd_en_q  <= 1'b0;
      rd_vld_q <= rd_en_q;
      if (pop) out_cnt_q <= out_cnt_q + 1'b1;

      case (state_q)
        StIdle: begin
          if (setup_frame) begin
            stride_q     <= stride_in;
            width_q      <= width_in;
            height_q     <= height_in;
            geom_valid_q <= 1'b1;
          end
          if (blk_req) begin
            if (req_ok) begin
              bx_q      <= blk_x;
              by_q      <= blk_y;
              rd_en_q   <= 1'b1;
              addr_q    <= ADDR_WIDTH'(next_addr);
              rd_cnt_q  <= (RowW + 1)'(1);
              out_cnt_q <= '0;
              state_q   <= StFetch;
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        StFetch: begin
          // rd_cnt_q only reaches 8 in the cycle the 8th strobe is driven.
          if (rd_cnt_q == (RowW + 1)'(BlkSize)) begin
            state_q <= StDrain;
          end else if (can_issue) begin
            rd_en_q  <= 1'b1;
            addr_q   <= ADDR_WIDTH'(next_addr);
            rd_cnt_q <= rd_cnt_q + 1'b1;
          end
        end
        StDrain: begin
          if (pop && (out_cnt_q == RowW'(BlkSize - 1))) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  fb_row_fifo #(
    .Width(MEM_WIDTH),
    .Depth(FIFO_DEPTH)
  ) u_row_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (rd_vld_q),
    .push_data(mem_rd_data),
    .pop      (pop),
    .head_data(fifo_head),
    .not_empty(fifo_nempty),
    .count    (fifo_cnt)
  );

  assign blk_busy  = (state_q != StIdle);
  assign blk_err   = err_q;
  assign mem_rd_en = rd_en_q;
  assign mem_addr  = addr_q;
  assign out_valid = fifo_nempty;
  // Stale FIFO storage is hidden so the port reads zero whenever nothing is valid.
  assign out_data  = fifo_nempty ? fifo_head : '0;
  assign out_row   = out_cnt_q;
  assign out_last  = fifo_nempty && (out_cnt_q == RowW'(BlkSize - 1));

endmodule

// File: tb/tb_frame_block_reader.sv
module tb_frame_block_reader;
  localparam int unsigned MW = 64;
  localparam int unsigned FD = 4;
  localparam int unsigned AW = 32;

  logic          clk = 1'b0;
  logic          reset, setup_frame, blk_req, out_ready;
  logic [11:0]   stride_in, width_in, height_in;
  logic [10:0]   blk_x, blk_y;
  logic          blk_busy, blk_err, mem_rd_en, out_valid, out_last;
  logic [AW-1:0] mem_addr;
  logic [MW-1:0] mem_rd_data, out_data;
  logic [2:0]    out_row;

  frame_block_reader #(
    .MEM_WIDTH (MW),
    .FIFO_DEPTH(FD),
    .ADDR_WIDTH(AW)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .setup_frame(setup_frame),
    .stride_in  (stride_in),
    .width_in   (width_in),
    .height_in  (height_in),
    .blk_req    (blk_req),
    .blk_x      (blk_x),
    .blk_y      (blk_y),
    .blk_busy   (blk_busy),
    .blk_err    (blk_err),
    .mem_rd_en  (mem_rd_en),
    .mem_addr   (mem_addr),
    .mem_rd_data(mem_rd_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_row    (out_row),
    .out_last   (out_last)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Memory contents are a fixed function of the word address.
  function automatic logic [MW-1:0] pat(input logic [AW-1:0] a);
    return {a ^ 32'hC0DE_5A00, (a * 32'h0100_0193) + 32'h0000_1234};
  endfunction

  // Data is valid only in the cycle after the strobe; junk otherwise.
  always @(posedge clk) mem_rd_data <= mem_rd_en ? pat(mem_addr) : {$urandom, $urandom};

  int total = 0;
  int bad = 0;
  int n_rd = 0;
  int first_rd = -1;
  int first_vld = -1;
  int last_out = -1;
  logic [AW-1:0] addr_q[$];
  logic [MW-1:0] dat_q[$];
  logic [2:0]    row_q[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_row(input int a, input int r);
    addr_q.push_back(AW'(a));
    dat_q.push_back(pat(AW'(a)));
    row_q.push_back(3'(r));
  endtask

  task automatic expect_block(input int stride, input int height, input int x, input int y);
    for (int r = 0; r < 8; r++) begin
      int yy;
      yy = (y + r > height - 1) ? height - 1 : y + r;
      expect_row((yy * stride + x) / 8, r);
    end
  endtask

  task automatic setup(input int s, input int w, input int h);
    stride_in   = 12'(s);
    width_in    = 12'(w);
    height_in   = 12'(h);
    setup_frame = 1'b1;
    tick();
    setup_frame = 1'b0;
  endtask

  task automatic req(input int x, input int y, output int acc);
    blk_x     = 11'(x);
    blk_y     = 11'(y);
    blk_req   = 1'b1;
    acc       = cyc;
    first_rd  = -1;
    first_vld = -1;
    tick();
    blk_req = 1'b0;
  endtask

  task automatic req_rejected(input string tag, input int x, input int y);
    int acc;
    int n0;
    n0 = n_rd;
    req(x, y, acc);
    check({tag, "_err"}, 64'(blk_err), 64'd1);
    check({tag, "_busy"}, 64'(blk_busy), 64'd0);
    tick();
    check({tag, "_err_pulse"}, 64'(blk_err), 64'd0);
    tick();
    check({tag, "_no_reads"}, 64'(n_rd - n0), 64'd0);
  endtask

  task automatic wait_idle(input string tag, input int limit, input bit rnd);
    int n;
    n = 0;
    while ((blk_busy || dat_q.size() != 0) && n < limit) begin
      if (rnd) out_ready = 1'($urandom_range(0, 1));
      tick();
      n++;
    end
    out_ready = 1'b1;
    check({tag, "_idle"}, 64'(blk_busy), 64'd0);
    check({tag, "_rows_left"}, 64'(dat_q.size()), 64'd0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, 64'(blk_busy), 64'd0);
    check({tag, "_err"}, 64'(blk_err), 64'd0);
    check({tag, "_rd_en"}, 64'(mem_rd_en), 64'd0);
    check({tag, "_addr"}, 64'(mem_addr), 64'd0);
    check({tag, "_valid"}, 64'(out_valid), 64'd0);
    check({tag, "_data"}, out_data, 64'd0);
    check({tag, "_row"}, 64'(out_row), 64'd0);
    check({tag, "_last"}, 64'(out_last), 64'd0);
  endtask

  // Scoreboard: reads and delivered rows are popped against bench expectations.
  initial begin : monitor
    logic [2:0] er;
    forever begin
      @(negedge clk);
      if (reset !== 1'b1) begin
        if (mem_rd_en) begin
          n_rd++;
          if (first_rd < 0) first_rd = cyc;
          if (addr_q.size() == 0) check("rd_unexpected", 64'(mem_rd_en), 64'd0);
          else check("rd_addr", 64'(mem_addr), 64'(addr_q.pop_front()));
        end
        if (out_valid && first_vld < 0) first_vld = cyc;
        if (out_valid && !out_ready && dat_q.size() != 0) begin
          check("hold_data", out_data, dat_q[0]);
          check("hold_row", 64'(out_row), 64'(row_q[0]));
        end
        if (out_valid && out_ready) begin
          if (dat_q.size() == 0) begin
            check("row_unexpected", 64'(out_valid), 64'd0);
          end else begin
            er = row_q.pop_front();
            check("row_data", out_data, dat_q.pop_front());
            check("row_idx", 64'(out_row), 64'(er));
            check("row_last", 64'(out_last), 64'(er == 3'd7));
            last_out = cyc;
          end
        end
      end
    end
  end

  initial begin
    int acc;
    int n0;
    reset = 1'b1; setup_frame = 1'b0; blk_req = 1'b0; out_ready = 1'b1;
    stride_in = '0; width_in = '0; height_in = '0; blk_x = '0; blk_y = '0;
    repeat (3) tick();
    check_all_zero("reset");
    reset = 1'b0;
    tick();

    // Any request before geometry is set is rejected.
    req_rejected("no_setup", 16, 8);

    // 352x288, block (16,8): addresses 354 + 44*r, back-to-back rows.
    setup(352, 352, 288);
    for (int r = 0; r < 8; r++) expect_row(354 + 44 * r, r);
    req(16, 8, acc);
    check("cif_busy", 64'(blk_busy), 64'd1);
    check("cif_no_err", 64'(blk_err), 64'd0);
    wait_idle("cif", 100, 1'b0);
    check("lat_first_rd", 64'(first_rd - acc), 64'd1);
    check("lat_first_vld", 64'(first_vld - acc), 64'd3);
    check("lat_last_row", 64'(last_out - acc), 64'd10);

    // Out-of-frame and misaligned requests.
    req_rejected("x_oob", 352, 0);
    req_rejected("x_misal", 3, 0);
    req_rejected("y_oob", 0, 288);

    // Bottom edge: rows past 283 replicate row 283.
    setup(352, 352, 284);
    for (int r = 0; r < 8; r++) expect_row((r < 4) ? 12320 + 44 * r : 12452, r);
    req(0, 280, acc);
    wait_idle("bottom", 100, 1'b0);

    // Consumer stalled: FIFO fills, no more reads, no data lost.
    setup(352, 352, 288);
    out_ready = 1'b0;
    expect_block(352, 288, 64, 16);
    n0 = n_rd;
    req(64, 16, acc);
    // Request and setup while busy must be ignored.
    blk_x = 11'd0; blk_y = 11'd0; blk_req = 1'b1;
    stride_in = 12'd176; height_in = 12'd284; setup_frame = 1'b1;
    tick();
    blk_req = 1'b0; setup_frame = 1'b0;
    check("busy_req_no_err", 64'(blk_err), 64'd0);
    repeat (9) tick();
    check("stall_reads_le4", 64'((n_rd - n0) <= 4), 64'd1);
    check("stall_valid", 64'(out_valid), 64'd1);
    check("stall_row0", 64'(out_row), 64'd0);
    out_ready = 1'b1;
    wait_idle("stall", 100, 1'b0);

    // Geometry must still be 352x288: no clamping at rows 280..287.
    expect_block(352, 288, 0, 280);
    req(0, 280, acc);
    wait_idle("geom_kept", 100, 1'b0);

    // Random backpressure.
    expect_block(352, 288, 344, 0);
    req(344, 0, acc);
    wait_idle("rand_ready", 300, 1'b1);

    // Reset in mid-fetch.
    expect_block(352, 288, 8, 0);
    req(8, 0, acc);
    tick();
    reset = 1'b1;
    addr_q.delete();
    dat_q.delete();
    row_q.delete();
    tick();
    check_all_zero("mid_reset");
    reset = 1'b0;
    req_rejected("post_reset_geom", 0, 0);
    check("post_reset_valid", 64'(out_valid), 64'd0);
    setup(352, 352, 288);
    expect_block(352, 288, 24, 40);
    req(24, 40, acc);
    wait_idle("post_reset", 100, 1'b0);
    check("post_reset_lat", 64'(first_vld - acc), 64'd3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
